// File: rtl/round_robin_arbiter_v2.sv
// Weighted, transaction-aware round-robin arbiter: registered one-hot grant 1 cycle after req, zero-bubble handover.
// A tenure lasts up to eff_weight complete transactions; ready low stalls beats and holds the grant indefinitely.
module round_robin_arbiter_v2 #(
   parameter int NUM_CLIENTS = 4,
   parameter int WEIGHT_W    = 4,
   localparam int IDX_W      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_CLIENTS-1:0]          req,
   input  logic [NUM_CLIENTS-1:0]          last,
   input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weight,
   input  logic                            ready,
   output logic [NUM_CLIENTS-1:0]          grant,
   output logic                            grant_valid,
   output logic [IDX_W-1:0]                grant_idx,
   output logic [WEIGHT_W-1:0]             credit
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                 state_q, state_d;
   logic [NUM_CLIENTS-1:0] grant_q, grant_d;
   logic                   valid_q, valid_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [WEIGHT_W-1:0]    credit_q, credit_d;

   logic                   cur_req, cur_last, beat, txn_done, release_now;
   logic [IDX_W-1:0]       nxt_idx, start_idx, win_idx;
   logic [NUM_CLIENTS-1:0] own_oh, masked_req, cand_req, win_oh;
   logic [WEIGHT_W-1:0]    win_weight;
   logic                   found;

   function automatic int wrap_add(input int a, input int b);
      int s;
      s = a + b;
      return (s >= NUM_CLIENTS) ? s - NUM_CLIENTS : s;
   endfunction

   always_comb begin
      cur_req     = req[idx_q];
      cur_last    = last[idx_q];
      beat        = valid_q & ready & cur_req;
      txn_done    = beat & cur_last;
      // Abandon covers a request dropped after its final beat as well as mid-transaction.
      release_now = valid_q & ((txn_done && (credit_q == WEIGHT_W'(1))) || !cur_req);

      nxt_idx = (idx_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : idx_q + IDX_W'(1);
      own_oh         = '0;
      own_oh[idx_q]  = 1'b1;
      masked_req     = req & ~own_oh;
      if (masked_req == '0) begin
         masked_req = req;
      end

      cand_req  = (state_q == GRANT) ? masked_req : req;
      start_idx = (state_q == GRANT) ? nxt_idx : ptr_q;

      found   = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (!found && cand_req[wrap_add(int'(start_idx), k)]) begin
            found   = 1'b1;
            win_idx = IDX_W'(wrap_add(int'(start_idx), k));
         end
      end

      win_oh          = '0;
      win_oh[win_idx] = 1'b1;
      win_weight      = weight[int'(win_idx)*WEIGHT_W +: WEIGHT_W];
      if (win_weight == '0) begin
         win_weight = WEIGHT_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      valid_d  = valid_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d  = GRANT;
               grant_d  = win_oh;
               valid_d  = 1'b1;
               idx_d    = win_idx;
               credit_d = win_weight;
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_d = nxt_idx;
               if (found) begin
                  grant_d  = win_oh;
                  idx_d    = win_idx;
                  credit_d = win_weight;
               end else begin
                  state_d  = IDLE;
                  grant_d  = '0;
                  valid_d  = 1'b0;
                  credit_d = '0;
               end
            end else if (txn_done) begin
               credit_d = credit_q - WEIGHT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         valid_q  <= 1'b0;
         idx_q    <= '0;
         ptr_q    <= '0;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         valid_q  <= valid_d;
         idx_q    <= idx_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = valid_q;
   assign grant_idx   = idx_q;
   assign credit      = credit_q;

endmodule

// File: tb/tb_round_robin_arbiter_v2.sv
// Directed scoreboard bench for round_robin_arbiter_v2: stimulus queues hand-computed post-edge outputs, a monitor checks them.
module tb_round_robin_arbiter_v2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  req = 4'b0000;
   logic [3:0]  last = 4'b0000;
   logic [15:0] weight = 16'h1111;
   logic        ready = 1'b0;
   logic [3:0]  grant;
   logic        grant_valid;
   logic [1:0]  grant_idx;
   logic [3:0]  credit;

   round_robin_arbiter_v2 dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .weight(weight), .ready(ready),
      .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .credit(credit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] g;
      logic [3:0] c;
      logic [1:0] i;
      logic       v;
      int         tag;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   int         n_total = 0;
   int         n_pass = 0;
   int         tag = 0;
   logic [1:0] exp_idx = 2'd0;

   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int k = 0; k < 4; k++) if (oh[k]) r = 2'(k);
      return r;
   endfunction

   task automatic check(input string nm, input int tg, input logic [3:0] g, input logic [3:0] c,
                        input logic [1:0] i, input logic v);
      n_total++;
      if (grant === g && credit === c && grant_idx === i && grant_valid === v) n_pass++;
      else $display("FAIL %s #%0d: got grant=%b credit=%0d idx=%0d valid=%b, expected grant=%b credit=%0d idx=%0d valid=%b",
                    nm, tg, grant, credit, grant_idx, grant_valid, g, c, i, v);
   endtask

   // Outputs expected after the coming rising edge.
   task automatic drive_push(input logic [3:0] r, input logic [3:0] l, input logic rd,
                             input logic [3:0] g, input logic [3:0] c);
      req   = r;
      last  = l;
      ready = rd;
      if (g != 4'b0000) exp_idx = oh2idx(g);
      sb_q.push_back('{g, c, exp_idx, |g, tag});
      tag++;
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rd,
                       input logic [3:0] g, input logic [3:0] c);
      @(negedge clk);
      drive_push(r, l, rd, g, c);
   endtask

   always begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         check("sb", mon_e.tag, mon_e.g, mon_e.c, mon_e.i, mon_e.v);
      end
   end

   initial begin
      #1 rst_n = 1'b0;
      #2 check("reset", 0, 4'b0000, 4'd0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Equal weights, everyone requesting: one transaction each in rotation.
      weight = 16'h1111;
      step(4'b1111, 4'b1111, 1'b1, 4'b0001, 4'd1);
      step(4'b1111, 4'b1111, 1'b1, 4'b0010, 4'd1);
      step(4'b1111, 4'b1111, 1'b1, 4'b0100, 4'd1);
      step(4'b1111, 4'b1111, 1'b1, 4'b1000, 4'd1);
      step(4'b1111, 4'b1111, 1'b1, 4'b0001, 4'd1);
      step(4'b0000, 4'b1111, 1'b1, 4'b0000, 4'd0);

      // Client0 weight 3 vs client1 weight 1, starting from ptr=1.
      weight = 16'h1113;
      step(4'b0011, 4'b0011, 1'b1, 4'b0010, 4'd1);
      step(4'b0011, 4'b0011, 1'b1, 4'b0001, 4'd3);
      step(4'b0011, 4'b0011, 1'b1, 4'b0001, 4'd2);
      step(4'b0011, 4'b0011, 1'b1, 4'b0001, 4'd1);
      step(4'b0011, 4'b0011, 1'b1, 4'b0010, 4'd1);
      step(4'b0011, 4'b0011, 1'b1, 4'b0001, 4'd3);
      step(4'b0011, 4'b0011, 1'b1, 4'b0001, 4'd2);
      step(4'b0011, 4'b0011, 1'b1, 4'b0001, 4'd1);
      step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'd0);

      // Client2 alone, 4-beat transaction under toggling ready, then sole-requester reload.
      weight = 16'h1213;
      step(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd2);
      step(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd2);
      step(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'd2);
      step(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd2);
      step(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'd2);
      step(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd2);
      step(4'b0100, 4'b0100, 1'b0, 4'b0100, 4'd2);
      step(4'b0100, 4'b0100, 1'b1, 4'b0100, 4'd1);
      step(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'd1);
      step(4'b0100, 4'b0100, 1'b1, 4'b0100, 4'd2);
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'd0);

      // Abandon: client1 (weight 5) drops mid-transaction, client3 (weight 4) takes over.
      weight = 16'h4153;
      step(4'b0010, 4'b0000, 1'b1, 4'b0010, 4'd5);
      step(4'b1010, 4'b0000, 1'b1, 4'b0010, 4'd5);
      step(4'b1010, 4'b0000, 1'b1, 4'b0010, 4'd5);
      step(4'b1000, 4'b0000, 1'b1, 4'b1000, 4'd4);
      step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'd0);

      // Weight 0 on client3 with ptr=3, then wrap to client0 without a bubble.
      weight = 16'h0113;
      step(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'd1);
      step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'd0);
      step(4'b1001, 4'b0000, 1'b1, 4'b1000, 4'd1);
      step(4'b1001, 4'b1000, 1'b1, 4'b0001, 4'd3);
      step(4'b1001, 4'b0000, 1'b1, 4'b0001, 4'd3);

      // Reset in the middle of a client1 tenure with credit 2.
      weight = 16'h0123;
      step(4'b0010, 4'b0000, 1'b1, 4'b0010, 4'd2);
      @(posedge clk);
      #3 rst_n = 1'b0;
      exp_idx = 2'd0;
      #1 check("rst_mid", 0, 4'b0000, 4'd0, 2'd0, 1'b0);
      req = 4'b0110;
      repeat (2) @(negedge clk);
      check("rst_hold", 0, 4'b0000, 4'd0, 2'd0, 1'b0);
      rst_n = 1'b1;
      drive_push(4'b0110, 4'b0000, 1'b1, 4'b0010, 4'd2);
      step(4'b0110, 4'b0010, 1'b1, 4'b0010, 4'd1);
      step(4'b0110, 4'b0010, 1'b1, 4'b0100, 4'd1);
      step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'd0);

      repeat (3) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/round_robin_arbiter_v2.md
Name: round_robin_arbiter_v2

Overview:
Weighted, transaction-aware round-robin arbiter for NUM_CLIENTS requesters sharing one downstream port. The grant is registered and one-hot. Once granted, a client holds the port for up to weight[i] complete transactions (delimited by last), unless it drops its request first. Back-to-back grants to different clients incur zero idle cycles. It replaces the single-cycle round-robin arbiter wherever burst fairness or bandwidth weighting is needed.

Parameters:
NUM_CLIENTS, 4, number of requesters (>=2)
WEIGHT_W, 4, width of each per-client weight field
IDX_W, $clog2(NUM_CLIENTS), width of grant_idx (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_CLIENTS  per-client request; held high for the duration of a transaction
last  input  NUM_CLIENTS  per-client end-of-transaction marker, qualified by beat
weight  input  NUM_CLIENTS*WEIGHT_W  client i weight in bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static
ready  input  1  downstream accepts a beat this cycle
grant  output  NUM_CLIENTS  registered one-hot grant; all-zero when idle
grant_valid  output  1  registered, equals |grant
grant_idx  output  IDX_W  registered index of granted client; holds last value when idle
credit  output  WEIGHT_W  remaining transactions in the current tenure (debug/observe)

Behaviour:
- Reset (async assert, sync release): grant=0, grant_valid=0, grant_idx=0, credit=0, ptr=0, state IDLE. Reset mid-tenure drops grant immediately, with no completion.
- ptr is an internal IDX_W pointer naming the highest-priority client. Search order is ptr, ptr+1, ..., NUM_CLIENTS-1, 0, ..., ptr-1. The first client with req=1 wins.
- beat = grant_valid & ready & req[grant_idx]. txn_done = beat & last[grant_idx].
- FSM states: IDLE, GRANT.
- IDLE: if |req, arbitrate from ptr. On the next edge: grant=onehot(w), grant_idx=w, credit=eff_weight(w), state GRANT. Grant therefore appears 1 cycle after req is sampled. If req=0, stay IDLE.
- eff_weight(i) = weight[i], except weight 0 is treated as 1. Weight is sampled only at grant time.
- GRANT, release conditions (evaluated each cycle):
  - (a) txn_done with credit==1, or
  - (b) txn_done with credit>1 and req[grant_idx] deasserted in the same cycle, or
  - (c) req[grant_idx]==0 outside a beat (abandon).
- GRANT, on release:
  - ptr <= grant_idx+1, wrapping NUM_CLIENTS-1 -> 0.
  - Re-arbitrate in the same cycle over req, masking grant_idx unless it is the sole requester, starting from grant_idx+1.
  - If a winner exists: load the new grant/credit at the edge and stay in GRANT (zero-bubble handover).
  - Otherwise: grant=0 and go to IDLE.
- GRANT, txn_done without release: credit decrements by 1 and the grant is held.
- GRANT, beat without last: no state change.
- ready low: grant held indefinitely, no timeout.
- grant never changes except at a release or at reset.
- At most one grant bit is set at any time.
- grant_idx always equals the index of the set grant bit while grant_valid=1.
- credit is never 0 while grant_valid=1, and is 0 in IDLE.
- last without beat is ignored. req/last of non-granted clients do not affect the current tenure.
- Sole requester with credit exhausted: re-granted on the next edge with credit reloaded, with no idle cycle.

Test Plan:
1. N=4, all weights=1; req=4'b1111 held, ready=1, last=1 every beat -> grant sequence 0001,0010,0100,1000,0001; one transaction each; grant_valid continuously 1 after the first cycle.
2. weight={1,1,1,3} (client0=3); req=4'b0011, single-beat transactions, ready=1 -> client0 receives 3 consecutive transactions (credit 3,2,1), then client1 receives 1, then client0 again; pattern repeats 3:1.
3. Client2 only: req=4'b0100, 4-beat transactions (last on beat 4), ready toggling 1,0,1,0 -> grant=0100 held through all ready-low cycles; credit decrements only on the beat with last; no spurious release.
4. Abandon: client1 granted with weight 5; req[1] drops after 2 beats with no last while req[3]=1 -> next edge grant=1000, credit=weight[3]; ptr advances to 2.
5. Weight 0 plus wrap: weight[3]=0, ptr at 3, req=4'b1001 -> client3 granted with credit=1; after its last, client0 granted (wrap 3->0) with no bubble.
6. Reset mid-tenure: rst_n asserted while grant=0010 with credit=2 -> grant, grant_valid and credit go to 0 asynchronously; after release with req=4'b0110, the first grant is 0010 (ptr=0 search).
